// File: rtl/data_memory_mmio.sv
// Data memory with a memory-mapped I/O window: RAM below IO_BASE, then GPIO
// and an 8-bit prescaled timer with compare match, auto-reload and a level IRQ.
// Reads are combinational. Writes commit on the rising clock edge.
module data_memory_mmio #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8,
    parameter logic [MEM_ADDR_WIDTH-1:0] IO_BASE = 8'hF0
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
    input  logic                      mem_WE,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
    input  logic [7:0]                gpio_in,
    output logic [7:0]                gpio_out,
    output logic                      irq
);

    // Register offsets relative to IO_BASE
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_GPIO_OUT = MEM_ADDR_WIDTH'(0);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_GPIO_IN  = MEM_ADDR_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TCNT     = MEM_ADDR_WIDTH'(2);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TCMP     = MEM_ADDR_WIDTH'(3);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TCTRL    = MEM_ADDR_WIDTH'(4);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TSTAT    = MEM_ADDR_WIDTH'(5);
    localparam logic [MEM_ADDR_WIDTH-1:0] OFF_TPRE     = MEM_ADDR_WIDTH'(6);

    // RAM is intentionally not reset
    logic [MEM_DATA_WIDTH-1:0] ram_mem [0:IO_BASE-1];

    logic [7:0] gpio_out_reg;
    logic [7:0] sync1_reg;
    logic [7:0] sync2_reg;
    logic [7:0] tcnt_reg;
    logic [7:0] tcmp_reg;
    logic [2:0] tctrl_reg;       // bit0 enable, bit1 auto-reload, bit2 irq enable
    logic       tstat_flag_reg;
    logic [7:0] tpre_reg;
    logic [7:0] presc_reg;

    logic                      in_ram;
    logic [MEM_ADDR_WIDTH-1:0] io_off;
    logic [7:0]                wdata;
    logic [7:0]                io_rdata;
    logic                      io_we;
    logic                      tick;
    logic                      match;

    assign in_ram = (mem_addr < IO_BASE);
    // Offset wraps for RAM addresses, so every I/O decode is qualified by !in_ram
    assign io_off = mem_addr - IO_BASE;
    assign wdata  = mem_data_i[7:0];
    assign io_we  = mem_WE && !in_ram;

    // Tick is judged from the current register values, so control writes act next cycle
    assign tick  = tctrl_reg[0] && (presc_reg == tpre_reg);
    assign match = (tcnt_reg == tcmp_reg);

    assign gpio_out = gpio_out_reg;
    assign irq      = tstat_flag_reg && tctrl_reg[2];

    // Combinational read mux; reserved offsets fall through to zero
    always_comb begin
        io_rdata = 8'h00;
        case (io_off)
            OFF_GPIO_OUT: io_rdata = gpio_out_reg;
            OFF_GPIO_IN:  io_rdata = sync2_reg;
            OFF_TCNT:     io_rdata = tcnt_reg;
            OFF_TCMP:     io_rdata = tcmp_reg;
            OFF_TCTRL:    io_rdata = {5'b00000, tctrl_reg};
            OFF_TSTAT:    io_rdata = {7'b0000000, tstat_flag_reg};
            OFF_TPRE:     io_rdata = tpre_reg;
            default:      io_rdata = 8'h00;
        endcase
        if (in_ram) begin
            mem_data_o = ram_mem[mem_addr];
        end else begin
            mem_data_o = MEM_DATA_WIDTH'(io_rdata);
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (mem_WE && in_ram) begin
            ram_mem[mem_addr] <= mem_data_i;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO input
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1_reg <= 8'h00;
            sync2_reg <= 8'h00;
        end else begin
            sync1_reg <= gpio_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Plain CPU-writable configuration registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            gpio_out_reg <= 8'h00;
            tcmp_reg     <= 8'h00;
            tctrl_reg    <= 3'b000;
            tpre_reg     <= 8'h00;
        end else if (io_we) begin
            if (io_off == OFF_GPIO_OUT) gpio_out_reg <= wdata;
            if (io_off == OFF_TCMP)     tcmp_reg     <= wdata;
            if (io_off == OFF_TCTRL)    tctrl_reg    <= wdata[2:0];
            if (io_off == OFF_TPRE)     tpre_reg     <= wdata;
        end
    end

    // Prescaler, counter and match flag; CPU load of TCNT beats a same-cycle tick
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc_reg      <= 8'h00;
            tcnt_reg       <= 8'h00;
            tstat_flag_reg <= 1'b0;
        end else begin
            if (io_we && io_off == OFF_TCNT) begin
                tcnt_reg  <= wdata;
                presc_reg <= 8'h00;
            end else if (!tctrl_reg[0]) begin
                presc_reg <= 8'h00;
            end else if (tick) begin
                presc_reg <= 8'h00;
                if (match) begin
                    if (tctrl_reg[1]) tcnt_reg <= 8'h00;
                end else begin
                    tcnt_reg <= tcnt_reg + 8'h01;
                end
            end else begin
                presc_reg <= presc_reg + 8'h01;
            end

            // A same-cycle match set wins over write-1-to-clear
            if (tick && match) begin
                tstat_flag_reg <= 1'b1;
            end else if (io_we && io_off == OFF_TSTAT && wdata[0]) begin
                tstat_flag_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, GPIO, timer one-shot and
// auto-reload, write collisions, reserved space and asynchronous reset.
module tb_data_memory_mmio;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] mem_addr = 8'h00;
    logic [7:0] mem_data_i = 8'h00;
    logic       mem_WE = 1'b0;
    logic [7:0] mem_data_o;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;
    logic       irq;

    int checks = 0;
    int failures = 0;

    data_memory_mmio dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .mem_addr  (mem_addr),
        .mem_data_i(mem_data_i),
        .mem_WE    (mem_WE),
        .mem_data_o(mem_data_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: start and end just after a falling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mem_addr = a; mem_data_i = d; mem_WE = 1'b1;
        @(negedge clk);
        mem_WE = 1'b0;
        $display("WR addr=%02h data=%02h", a, d);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        mem_addr = a;
        #1;
        d = mem_data_o;
        $display("RD addr=%02h data=%02h", a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        @(negedge clk);
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_gpio_out got=%02h exp=00", gpio_out); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        for (int i = 0; i < 7; i++) begin
            rd(8'hF0 + 8'(i), d);
            checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg_%0d got=%02h exp=00", i, d); end
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram;
        logic [7:0] d;
        wr(8'h10, 8'h5A);
        rd(8'h10, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL ram_rd got=%02h exp=5A", d); end
        // Read during the write cycle returns the old value
        mem_addr = 8'h10; mem_data_i = 8'hA5; mem_WE = 1'b1;
        #1;
        checks++; if (mem_data_o !== 8'h5A) begin failures++; $display("FAIL ram_rd_during_wr got=%02h exp=5A", mem_data_o); end
        @(negedge clk);
        mem_WE = 1'b0;
        rd(8'h10, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL ram_rd_after_wr got=%02h exp=A5", d); end
        wr(8'h00, 8'h11);
        wr(8'hEF, 8'h22);
        rd(8'h00, d);
        checks++; if (d !== 8'h11) begin failures++; $display("FAIL ram_lo got=%02h exp=11", d); end
        rd(8'hEF, d);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL ram_hi got=%02h exp=22", d); end
    endtask

    task automatic test_gpio;
        logic [7:0] d;
        wr(8'hF0, 8'hC3);
        checks++; if (gpio_out !== 8'hC3) begin failures++; $display("FAIL gpio_out got=%02h exp=C3", gpio_out); end
        rd(8'hF0, d);
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL gpio_out_rd got=%02h exp=C3", d); end
        gpio_in = 8'h81;
        rd(8'hF1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL gpio_in_0edge got=%02h exp=00", d); end
        @(negedge clk);
        rd(8'hF1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL gpio_in_1edge got=%02h exp=00", d); end
        @(negedge clk);
        rd(8'hF1, d);
        checks++; if (d !== 8'h81) begin failures++; $display("FAIL gpio_in_2edge got=%02h exp=81", d); end
        wr(8'hF1, 8'h55);
        rd(8'hF1, d);
        checks++; if (d !== 8'h81) begin failures++; $display("FAIL gpio_in_ro got=%02h exp=81", d); end
    endtask

    task automatic test_oneshot;
        logic [7:0] d;
        wr(8'hF6, 8'h02);
        wr(8'hF3, 8'h03);
        wr(8'hF2, 8'h00);
        wr(8'hF5, 8'h01);
        wr(8'hF4, 8'h05);    // enable commits on this edge (E0)
        idle(11);            // through E11
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_e11 got=%b exp=0", irq); end
        rd(8'hF2, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL oneshot_tcnt_e11 got=%02h exp=03", d); end
        idle(1);             // E12: match tick
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_e12 got=%b exp=1", irq); end
        rd(8'hF5, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL oneshot_flag got=%02h exp=01", d); end
        idle(6);             // E18 (a tick edge)
        rd(8'hF2, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL oneshot_tcnt_hold got=%02h exp=03", d); end
        wr(8'hF5, 8'h01);    // E19, no tick
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_w1c_irq got=%b exp=0", irq); end
        wr(8'hF4, 8'h00);    // E20, disable before the next tick
        idle(5);
        rd(8'hF2, d);
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL oneshot_disabled_hold got=%02h exp=03", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_disabled_irq got=%b exp=0", irq); end
    endtask

    task automatic test_autoreload;
        logic [7:0] d;
        logic [7:0] exp_seq [0:3];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01; exp_seq[3] = 8'h00;
        wr(8'hF6, 8'h00);
        wr(8'hF3, 8'h01);
        wr(8'hF2, 8'h00);
        wr(8'hF5, 8'h01);
        wr(8'hF4, 8'h03);
        rd(8'hF2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL ar_tcnt_start got=%02h exp=00", d); end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            rd(8'hF2, d);
            checks++; if (d !== exp_seq[i]) begin failures++; $display("FAIL ar_tcnt_%0d got=%02h exp=%02h", i, d, exp_seq[i]); end
            if (i == 1) begin
                rd(8'hF5, d);
                checks++; if (d !== 8'h01) begin failures++; $display("FAIL ar_flag got=%02h exp=01", d); end
            end
        end
        rd(8'hF5, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL ar_flag_held got=%02h exp=01", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ar_irq_masked got=%b exp=0", irq); end
        wr(8'hF4, 8'h00);
        wr(8'hF5, 8'h01);
    endtask

    task automatic test_collision;
        logic [7:0] d;
        // TCNT write on a tick edge
        wr(8'hF6, 8'h00);
        wr(8'hF3, 8'h80);
        wr(8'hF2, 8'h00);
        wr(8'hF4, 8'h01);
        idle(2);
        rd(8'hF2, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL col_tcnt_run got=%02h exp=02", d); end
        wr(8'hF2, 8'h40);
        rd(8'hF2, d);
        checks++; if (d !== 8'h40) begin failures++; $display("FAIL col_tcnt_wr got=%02h exp=40", d); end
        idle(1);
        rd(8'hF2, d);
        checks++; if (d !== 8'h41) begin failures++; $display("FAIL col_tcnt_next got=%02h exp=41", d); end
        wr(8'hF4, 8'h00);
        // W1C on the first match edge
        wr(8'hF3, 8'h02);
        wr(8'hF2, 8'h00);
        wr(8'hF5, 8'h01);
        wr(8'hF4, 8'h01);    // E0
        idle(2);             // E1, E2 -> TCNT=2
        wr(8'hF5, 8'h01);    // E3 match tick
        rd(8'hF5, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL col_w1c_set_wins got=%02h exp=01", d); end
        wr(8'hF4, 8'h00);
        wr(8'hF5, 8'h01);
        rd(8'hF5, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL col_w1c_clear got=%02h exp=00", d); end
        // Counter wraps 0xFF -> 0x00
        wr(8'hF3, 8'h05);
        wr(8'hF2, 8'hFE);
        wr(8'hF4, 8'h01);
        idle(1);
        rd(8'hF2, d);
        checks++; if (d !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%02h exp=FF", d); end
        idle(1);
        rd(8'hF2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL wrap_00 got=%02h exp=00", d); end
        wr(8'hF4, 8'h00);
    endtask

    task automatic test_reserved;
        logic [7:0] d;
        wr(8'hF9, 8'hFF);
        rd(8'hF9, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rsv_f9 got=%02h exp=00", d); end
        wr(8'hF7, 8'hAA);
        rd(8'hF7, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rsv_f7 got=%02h exp=00", d); end
        rd(8'hFF, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rsv_ff got=%02h exp=00", d); end
        wr(8'hF4, 8'hF8);
        rd(8'hF4, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL tctrl_hi_bits got=%02h exp=00", d); end
        rd(8'hF0, d);
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL rsv_no_alias got=%02h exp=C3", d); end
    endtask

    task automatic test_reset_midcount;
        logic [7:0] d;
        wr(8'hF6, 8'h00);
        wr(8'hF3, 8'h07);
        wr(8'hF2, 8'h00);
        wr(8'hF5, 8'h01);
        wr(8'hF4, 8'h05);
        idle(8);             // TCNT reaches 7 on E7, flag on E8
        rd(8'hF2, d);
        checks++; if (d !== 8'h07) begin failures++; $display("FAIL rst_pre_tcnt got=%02h exp=07", d); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rst_pre_irq got=%b exp=1", irq); end
        arst_n = 1'b0;
        #1;
        checks++; if (mem_data_o !== 8'h00) begin failures++; $display("FAIL rst_async_tcnt got=%02h exp=00", mem_data_o); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_async_irq got=%b exp=0", irq); end
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL rst_async_gpio got=%02h exp=00", gpio_out); end
        @(negedge clk);
        arst_n = 1'b1;
        idle(4);
        rd(8'hF2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_after_tcnt got=%02h exp=00", d); end
        rd(8'hF4, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_after_tctrl got=%02h exp=00", d); end
    endtask

    initial begin
        test_reset;
        test_ram;
        test_gpio;
        test_oneshot;
        test_autoreload;
        test_collision;
        test_reserved;
        test_reset_midcount;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and arst_n.
REQ-002 Parameter MEM_ADDR_WIDTH SHALL default to 8 and set the data-bus address width.
REQ-003 Parameter MEM_DATA_WIDTH SHALL default to 8 and set the data-bus data width.
REQ-004 Parameter IO_BASE SHALL default to 8'hF0 and set the first memory-mapped I/O address.
REQ-005 Port clk SHALL be an input of width 1 and act as the system clock; all state is rising-edge.
REQ-006 Port arst_n SHALL be an input of width 1 and act as the asynchronous active-low reset.
REQ-007 Port mem_addr SHALL be an input of width MEM_ADDR_WIDTH carrying the access address from the CPU.
REQ-008 Port mem_data_i SHALL be an input of width MEM_DATA_WIDTH carrying the CPU write data.
REQ-009 Port mem_WE SHALL be an input of width 1 and act as the write strobe, with one write per high cycle.
REQ-010 Port mem_data_o SHALL be an output of width MEM_DATA_WIDTH carrying read data to the CPU.
REQ-011 Port gpio_in SHALL be an input of width 8 carrying an asynchronous external input port.
REQ-012 Port gpio_out SHALL be an output of width 8 driven by the GPIO_OUT register.
REQ-013 Port irq SHALL be an output of width 1 and act as the timer interrupt request (level).

Function
REQ-014 The address map SHALL be as follows, with all addresses absolute.
- 0x00..IO_BASE-1: RAM.
- 0xF0: GPIO_OUT (RW).
- 0xF1: GPIO_IN (RO).
- 0xF2: TCNT (RW).
- 0xF3: TCMP (RW).
- 0xF4: TCTRL (RW): bit0 enable, bit1 auto-reload, bit2 irq enable; bits 7:3 read 0.
- 0xF5: TSTAT (bit0 match flag, write-1-to-clear).
- 0xF6: TPRE (RW).
- 0xF7..0xFF: reserved.
REQ-015 Reads SHALL be combinational: mem_data_o reflects the current mem_addr in the same cycle with zero-cycle latency, independent of mem_WE.
REQ-016 Writes SHALL commit on the rising edge at which mem_WE=1, using the mem_addr and mem_data_i values sampled at that edge.
REQ-017 A read of an address in the same cycle as a write to it SHALL return the pre-write value; the new value SHALL be visible from the next cycle.
REQ-018 Reserved addresses SHALL read 0x00, and writes to them SHALL be ignored.
REQ-019 Read-only registers SHALL ignore writes.
REQ-020 gpio_in SHALL pass through a 2-flop synchronizer; GPIO_IN SHALL read the second flop, giving 2-cycle latency.
REQ-021 gpio_out SHALL equal GPIO_OUT continuously.
REQ-022 Prescaler (internal 8-bit): when TCTRL.enable=1, it SHALL count 0..TPRE and emit a tick in the cycle it equals TPRE, then reset to 0. The tick period is TPRE+1 clocks.
REQ-023 When TCTRL.enable=0, the prescaler SHALL be held at 0 and TCNT SHALL hold its value.
REQ-024 On a tick with TCNT==TCMP, TSTAT.flag SHALL set to 1 and TCNT SHALL go to 0 if auto-reload=1, otherwise TCNT SHALL hold.
REQ-025 On a tick with TCNT!=TCMP, TCNT SHALL increment modulo 256, wrapping 0xFF->0x00.
REQ-026 A CPU write to TCNT SHALL load TCNT and clear the prescaler, and SHALL take priority over a same-cycle tick.
REQ-027 A TSTAT write with bit0=1 SHALL clear the flag; if a match sets the flag in the same cycle, set SHALL win.
REQ-028 irq SHALL equal TSTAT.flag AND TCTRL.irq_en, combinationally from registers.
REQ-029 Writes to TCMP, TPRE or TCTRL SHALL take effect for tick evaluation from the next cycle.

Reset
REQ-030 On arst_n low, the following SHALL be cleared immediately and asynchronously:
- GPIO_OUT, TCNT, TCMP, TCTRL, TSTAT and TPRE to 0x00.
- The prescaler and both synchronizer stages to 0.
- gpio_out=0x00 and irq=0.
REQ-031 RAM contents SHALL NOT be reset; they are undefined until written.
REQ-032 Reset asserted mid-count SHALL abandon the count; after release the timer SHALL remain disabled until TCTRL is written.
REQ-033 Reset deassertion SHALL be synchronous to clk.

Verification
REQ-034 RAM: write 0x5A to 0x10, then read 0x10 -> mem_data_o=0x5A. Read 0x10 in the write cycle -> old value.
REQ-035 GPIO:
- Write 0xC3 to 0xF0 -> gpio_out=0xC3 next cycle.
- Drive gpio_in=0x81 -> 0xF1 reads 0x81 after 2 edges, 0x00 before.
REQ-036 Timer one-shot: TPRE=2, TCMP=3, TCTRL=0x05.
- Flag SHALL set 12 cycles after the enable write commits.
- irq=1 from that point; TCNT SHALL hold at 3.
- Write 0x01 to 0xF5 -> irq=0.
REQ-037 Auto-reload: TPRE=0, TCMP=1, TCTRL=0x03 -> TCNT sequence 0,1,0,1; flag set at the first match and held.
REQ-038 Collisions:
- TCNT write in the same cycle as a tick -> written value wins.
- W1C in the same cycle as a match -> flag stays 1.
- Reserved 0xF9 write of 0xFF -> 0xF9 reads 0x00.
REQ-039 Reset mid-count: assert arst_n=0 with TCNT=0x07, irq=1 -> TCNT=0x00, irq=0 and gpio_out=0x00 immediately, with no clock edge required.
